// File: rtl/instr_encoder.sv
// Encodes a stream of MIPS instruction commands into machine words and writes
// them to instruction memory at consecutive word addresses through a 2-entry queue.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_kind,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [25:0] cmd_imm,
    output logic        im_we,
    input  logic        im_wready,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        err,
    output logic [15:0] words_written
);

    localparam int unsigned      IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [31:0]      BASE_AL   = {BASE_ADDR[31:2], 2'b00};

    localparam logic [3:0] K_ADD = 4'd0;
    localparam logic [3:0] K_SUB = 4'd1;
    localparam logic [3:0] K_ORI = 4'd2;
    localparam logic [3:0] K_LUI = 4'd3;
    localparam logic [3:0] K_LW  = 4'd4;
    localparam logic [3:0] K_SW  = 4'd5;
    localparam logic [3:0] K_BEQ = 4'd6;
    localparam logic [3:0] K_JAL = 4'd7;
    localparam logic [3:0] K_JR  = 4'd8;
    localparam logic [3:0] K_NOP = 4'd9;

    // Queue: the head slot drives im_wdata/im_we directly; slot1 is the tail.
    logic              slot1_vld;
    logic [31:0]       slot1;
    logic [IDX_W-1:0]  idx;

    logic              enc_legal_c;
    logic [31:0]       enc_word_c;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;

    logic              head_vld_nxt;
    logic [31:0]       head_nxt;
    logic              slot1_vld_nxt;
    logic [31:0]       slot1_nxt;
    logic              ready_nxt;
    logic              err_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [31:0]       addr_nxt;
    logic [15:0]       words_nxt;

    // Command-to-machine-word encoder; fields a kind does not use never reach the word.
    always_comb begin
        enc_word_c  = 32'h0;
        enc_legal_c = 1'b1;
        case (cmd_kind)
            K_ADD:   enc_word_c = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100000};
            K_SUB:   enc_word_c = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100010};
            K_ORI:   enc_word_c = {6'b001101, cmd_rs, cmd_rt, cmd_imm[15:0]};
            K_LUI:   enc_word_c = {6'b001111, 5'b00000, cmd_rt, cmd_imm[15:0]};
            K_LW:    enc_word_c = {6'b100011, cmd_rs, cmd_rt, cmd_imm[15:0]};
            K_SW:    enc_word_c = {6'b101011, cmd_rs, cmd_rt, cmd_imm[15:0]};
            K_BEQ:   enc_word_c = {6'b000100, cmd_rs, cmd_rt, cmd_imm[15:0]};
            K_JAL:   enc_word_c = {6'b000011, cmd_imm};
            K_JR:    enc_word_c = {6'b000000, cmd_rs, 15'b0, 6'b001000};
            K_NOP:   enc_word_c = 32'h0;
            default: enc_legal_c = 1'b0;
        endcase
    end

    // Next-state: queue shift/fill, address index, write counter, error pulse.
    always_comb begin
        accept_c      = cmd_valid & cmd_ready;
        push_c        = accept_c & enc_legal_c;
        pop_c         = im_we & im_wready;

        head_vld_nxt  = im_we;
        head_nxt      = im_wdata;
        slot1_vld_nxt = slot1_vld;
        slot1_nxt     = slot1;
        idx_nxt       = idx;
        addr_nxt      = im_addr;
        words_nxt     = words_written;
        err_nxt       = accept_c & ~enc_legal_c;

        if (pop_c) begin
            head_vld_nxt  = slot1_vld;
            head_nxt      = slot1;
            slot1_vld_nxt = 1'b0;
            idx_nxt       = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            addr_nxt      = BASE_AL + {30'(idx_nxt), 2'b00};
            words_nxt     = (words_written == 16'hFFFF) ? words_written
                                                        : words_written + 16'd1;
        end

        if (push_c) begin
            if (!head_vld_nxt) begin
                head_vld_nxt  = 1'b1;
                head_nxt      = enc_word_c;
            end else begin
                slot1_vld_nxt = 1'b1;
                slot1_nxt     = enc_word_c;
            end
        end

        ready_nxt = ~(head_vld_nxt & slot1_vld_nxt);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_we         <= 1'b0;
            im_wdata      <= 32'h0;
            slot1_vld     <= 1'b0;
            slot1         <= 32'h0;
            cmd_ready     <= 1'b0;
            err           <= 1'b0;
            idx           <= '0;
            im_addr       <= BASE_AL;
            words_written <= 16'h0;
        end else begin
            im_we         <= head_vld_nxt;
            im_wdata      <= head_nxt;
            slot1_vld     <= slot1_vld_nxt;
            slot1         <= slot1_nxt;
            cmd_ready     <= ready_nxt;
            err           <= err_nxt;
            idx           <= idx_nxt;
            im_addr       <= addr_nxt;
            words_written <= words_nxt;
        end
    end

endmodule
